// File: rtl/expr_pipe_pkg.sv
// expr_pipe_pkg: shared opcode encoding and operand helpers for expr_pipe.
// Helpers work on a fixed CW-bit signed container, so W and RW must be
// 32 or less for a full-precision product to fit.
package expr_pipe_pkg;

  localparam int OP_W = 3;
  localparam int CW   = 64;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_LT   = 3'd5,
    OP_NE   = 3'd6,
    OP_XRED = 3'd7
  } op_e;

  // Widen a w-bit operand held in the low bits of v: sign- or zero-extend.
  function automatic logic signed [CW-1:0] ext(input logic [CW-1:0] v,
                                               input int w, input logic s);
    logic [CW-1:0] m;
    m = {CW{1'b1}} << w;
    if (s && v[w-1]) ext = v | m;
    else             ext = v & ~m;
  endfunction

  // Clamp a full-precision result into the w-bit signed or unsigned range.
  function automatic logic signed [CW-1:0] sat(input logic signed [CW-1:0] v,
                                               input int w, input logic s);
    logic signed [CW-1:0] hi, lo;
    if (s) begin
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
    end else begin
      hi = (64'sd1 <<< w) - 64'sd1;
      lo = '0;
    end
    if (v > hi)      sat = hi;
    else if (v < lo) sat = lo;
    else             sat = v;
  endfunction

endpackage

// File: rtl/expr_pipe_alu.sv
// expr_alu: one combinational channel of expr_pipe.
// Optional build macro EXPR_PIPE_SAT_EN: ADD/SUB/MUL saturate instead of wrap.
module expr_alu
  import expr_pipe_pkg::*;
#(
  parameter int W  = 6,
  parameter int RW = 6
) (
  input  logic [W-1:0]    i_a,
  input  logic [W-1:0]    i_b,
  input  logic            i_sgn,
  input  logic [OP_W-1:0] i_op,
  output logic [RW-1:0]   o_y
);

  localparam int            E      = (W > RW) ? W : RW;
  localparam logic [CW-1:0] E_MASK = ~({CW{1'b1}} << E);
  localparam logic [CW-1:0] RW_LIM = CW'(RW);

  logic signed [CW-1:0] w_a, w_b, w_full;
  logic        [CW-1:0] w_sh;
  logic                 w_unused;

  // Operands are widened once; all arithmetic runs at full precision and
  // is narrowed to RW at the output.
  assign w_a  = ext(CW'(i_a), W, i_sgn);
  assign w_b  = ext(CW'(i_b), W, i_sgn);
  assign w_sh = CW'(i_b);  // shift amount is always unsigned

  // Opcode decode into a full-precision result.
  always_comb begin
    w_full = '0;
    case (op_e'(i_op))
      OP_ADD:  w_full = w_a + w_b;
      OP_SUB:  w_full = w_a - w_b;
      OP_MUL:  w_full = w_a * w_b;
      OP_SHL:  w_full = (w_sh >= RW_LIM) ? '0 : (w_a << w_sh);
      OP_SHR: begin
        if (w_sh >= RW_LIM) w_full = (i_sgn && w_a[CW-1]) ? '1 : '0;
        else                w_full = w_a >>> w_sh;  // zero-extended when unsigned
      end
      OP_LT:   w_full = CW'(w_a < w_b);
      OP_NE:   w_full = CW'(w_a != w_b);
      OP_XRED: w_full = CW'(^((w_a ^ w_b) & E_MASK));
      default: w_full = '0;
    endcase
  end

`ifdef EXPR_PIPE_SAT_EN
  logic signed [CW-1:0] w_sat;
  assign w_sat    = sat(w_full, RW, i_sgn);
  assign o_y      = (i_op inside {OP_ADD, OP_SUB, OP_MUL}) ? w_sat[RW-1:0]
                                                         : w_full[RW-1:0];
  assign w_unused = ^{w_full, w_sat};
`else
  assign o_y      = w_full[RW-1:0];
  assign w_unused = ^w_full;
`endif

endmodule

// File: rtl/expr_pipe.sv
// expr_pipe: NCH-channel expression evaluator, LAT-deep valid/ready pipeline.
// Stage 1 holds the ALU results; stages 2..LAT are plain registers.
// Optional build macro EXPR_PIPE_SAT_EN (see expr_alu). LAT legal range 1..4.
module expr_pipe
  import expr_pipe_pkg::*;
#(
  parameter int NCH = 6,
  parameter int W   = 6,
  parameter int RW  = 6,
  parameter int LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NCH*W-1:0]    a,
  input  logic [NCH*W-1:0]    b,
  input  logic [NCH-1:0]      sgn,
  input  logic [NCH*OP_W-1:0] op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NCH*RW-1:0]   y,
  output logic [15:0]         out_cnt
);

  logic                          w_en;
  logic [NCH-1:0][RW-1:0]        w_res;
  logic [LAT:1]                  r_vld_pipe;
  logic [LAT:1][NCH*RW-1:0]      r_dat_pipe;
  logic [15:0]                   r_cnt;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    expr_alu #(.W(W), .RW(RW)) u_alu (
      .i_a   (a[i*W +: W]),
      .i_b   (b[i*W +: W]),
      .i_sgn (sgn[i]),
      .i_op  (op[i*OP_W +: OP_W]),
      .o_y   (w_res[i])
    );
  end

  // The whole pipe moves as one: bubbles keep their slot, and a stalled
  // output freezes every stage.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Valid and data shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else if (w_en) begin
      r_vld_pipe[1] <= in_valid;
      r_dat_pipe[1] <= w_res;
      for (int s = 2; s <= LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  // Completed output handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (out_valid && out_ready) r_cnt <= r_cnt + 16'd1;
  end

  assign out_valid = r_vld_pipe[LAT];
  assign y         = r_dat_pipe[LAT];
  assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_expr_pipe.sv
// tb_expr_pipe: randomized and directed checks of expr_pipe against an
// arithmetic reference model and a slot-queue model of the pipeline.
module tb_expr_pipe;
  localparam int NCH = 6, W = 6, RW = 6, LAT = 2;

  logic              clk = 1'b0, rst = 1'b1;
  logic              in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [NCH*W-1:0]  a = '0, b = '0;
  logic [NCH-1:0]    sgn = '0;
  logic [NCH*3-1:0]  op = '0;
  logic [NCH*RW-1:0] y;
  logic [15:0]       out_cnt;

  int checks = 0, errors = 0;

  typedef struct { bit v; logic [NCH*RW-1:0] d; } ent_t;
  ent_t        mp[$];
  logic [15:0] ecnt;

  always #5 clk = ~clk;

  expr_pipe #(.NCH(NCH), .W(W), .RW(RW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .out_cnt(out_cnt)
  );

  // Reference: operands as integers, result per opcode, then fit to RW bits.
  function automatic logic [RW-1:0] exp_ch(input logic [W-1:0] ca, input logic [W-1:0] cb,
                                           input bit s, input logic [2:0] cop);
    longint va, vb, vbu, r;
    va  = s ? longint'($signed(ca)) : longint'(ca);
    vb  = s ? longint'($signed(cb)) : longint'(cb);
    vbu = longint'(cb);
    case (cop)
      3'd0:    r = va + vb;
      3'd1:    r = va - vb;
      3'd2:    r = va * vb;
      3'd3:    r = (vbu >= RW) ? 0 : va * (longint'(1) << vbu);
      3'd4:    r = (vbu >= RW) ? ((va < 0) ? -1 : 0) : (va >>> vbu);
      3'd5:    r = (va < vb) ? 1 : 0;
      3'd6:    r = (va != vb) ? 1 : 0;
      default: r = $countones(ca ^ cb) % 2;
    endcase
`ifdef EXPR_PIPE_SAT_EN
    if (cop <= 3'd2) begin
      longint hi, lo;
      hi = s ? (longint'(1) <<< (RW - 1)) - 1 : (longint'(1) <<< RW) - 1;
      lo = s ? -(longint'(1) <<< (RW - 1)) : 0;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
    end
`endif
    return r[RW-1:0];
  endfunction

  function automatic logic [NCH*RW-1:0] exp_vec(input logic [NCH*W-1:0] va, input logic [NCH*W-1:0] vb,
                                                input logic [NCH-1:0] vs, input logic [NCH*3-1:0] vop);
    logic [NCH*RW-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++)
      r[i*RW +: RW] = exp_ch(va[i*W +: W], vb[i*W +: W], vs[i], vop[i*3 +: 3]);
    return r;
  endfunction

  task automatic drive_rand(input bit iv);
    in_valid = iv;
    for (int i = 0; i < NCH; i++) begin
      a[i*W +: W]  = W'($urandom);
      b[i*W +: W]  = ($urandom % 2 == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      op[i*3 +: 3] = 3'($urandom);
    end
    sgn = NCH'($urandom);
  endtask

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0; e.d = '0;
    mp.delete();
    repeat (LAT) mp.push_back(e);
    ecnt = '0;
  endtask

  // One clock of the pipeline model using the currently driven inputs.
  task automatic model_advance();
    ent_t e;
    bit   ov;
    ov = mp[$].v;
    if (ov && out_ready) ecnt = ecnt + 16'd1;
    if (!ov || out_ready) begin
      e.v = in_valid;
      e.d = exp_vec(a, b, sgn, op);
      mp.push_front(e);
      void'(mp.pop_back());
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
    checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", out_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    model_reset();
  endtask

  task automatic test_directed();
    logic [5:0] ta[8], tbv[8], te[8];
    logic [2:0] to[8];
    bit         ts[8];
    logic [NCH*RW-1:0] expv;
    ta  = '{6'h3D, 6'h30, 6'h30, 6'h15, 6'h3F, 6'h3F, 6'h09, 6'h1F};
    tbv = '{6'h05, 6'h02, 6'h02, 6'h07, 6'h01, 6'h01, 6'h09, 6'h01};
    ts  = '{1, 1, 0, 0, 1, 0, 0, 1};
    to  = '{3'd0, 3'd4, 3'd4, 3'd3, 3'd5, 3'd5, 3'd2, 3'd0};
`ifdef EXPR_PIPE_SAT_EN
    te  = '{6'h02, 6'h3C, 6'h0C, 6'h00, 6'h01, 6'h00, 6'h3F, 6'h1F};
`else
    te  = '{6'h02, 6'h3C, 6'h0C, 6'h00, 6'h01, 6'h00, 6'h11, 6'h20};
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_rand(1'b1);
      a[5:0] = ta[k]; b[5:0] = tbv[k]; sgn[0] = ts[k]; op[2:0] = to[k];
      expv = exp_vec(a, b, sgn, op);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early got %b want 0", k, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got %b want 1", k, out_valid); end
      checks++; if (y[RW-1:0] !== te[k]) begin errors++; $display("FAIL dir%0d_ch0 got %h want %h", k, y[RW-1:0], te[k]); end
      checks++; if (y !== expv) begin errors++; $display("FAIL dir%0d_y got %h want %h", k, y, expv); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_after got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      checks++; if (out_valid !== mp[$].v) begin errors++; $display("FAIL rand_valid c%0d got %b want %b", c, out_valid, mp[$].v); end
      if (mp[$].v) begin
        checks++; if (y !== mp[$].d) begin errors++; $display("FAIL rand_y c%0d got %h want %h", c, y, mp[$].d); end
      end
      checks++; if (out_cnt !== ecnt) begin errors++; $display("FAIL rand_cnt c%0d got %0d want %0d", c, out_cnt, ecnt); end
      out_ready = ($urandom % 4) != 0;
      drive_rand(($urandom % 4) != 0);
      #1;
      checks++; if (in_ready !== (!mp[$].v || out_ready)) begin errors++; $display("FAIL rand_ready c%0d got %b", c, in_ready); end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    bit stall;
    logic [NCH*RW-1:0] prev_y;
    apply_reset();
    sent = 0;
    prev_y = '0;
    for (int c = 0; c < 16; c++) begin
      checks++; if (out_valid !== mp[$].v) begin errors++; $display("FAIL b2b_valid c%0d got %b want %b", c, out_valid, mp[$].v); end
      if (mp[$].v) begin
        checks++; if (y !== mp[$].d) begin errors++; $display("FAIL b2b_y c%0d got %h want %h", c, y, mp[$].d); end
      end
      checks++; if (out_cnt !== ecnt) begin errors++; $display("FAIL b2b_cnt c%0d got %0d want %0d", c, out_cnt, ecnt); end
      if (c >= 5 && c <= 7) begin
        checks++; if (out_valid !== 1'b1 || y !== prev_y) begin errors++; $display("FAIL b2b_hold c%0d got %b/%h want 1/%h", c, out_valid, y, prev_y); end
      end
      prev_y = y;
      stall = (c >= 4 && c <= 6);
      out_ready = !stall;
      if (sent < 8) drive_rand(1'b1);
      else          in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== !stall) begin errors++; $display("FAIL b2b_ready c%0d got %b want %b", c, in_ready, !stall); end
      if (in_valid && (!mp[$].v || out_ready)) sent++;
      model_advance();
      @(posedge clk); #1;
    end
    checks++; if (out_cnt !== 16'd8) begin errors++; $display("FAIL b2b_total got %0d want 8", out_cnt); end
  endtask

  task automatic test_reset_midflight();
    logic [NCH*RW-1:0] expv;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_rand(1'b1);
      model_advance();
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b1 || out_cnt !== ecnt) begin errors++; $display("FAIL mid_pre got %b/%0d want 1/%0d", out_valid, out_cnt, ecnt); end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (y !== '0) begin errors++; $display("FAIL mid_rst_y got %h want 0", y); end
    checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", out_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale c%0d got %b want 0", c, out_valid); end
      @(posedge clk); #1;
    end
    drive_rand(1'b1);
    expv = exp_vec(a, b, sgn, op);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_lat1 got %b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || y !== expv) begin errors++; $display("FAIL mid_lat2 got %b/%h want 1/%h", out_valid, y, expv); end
    checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", out_cnt); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
